wb_sram8_slave: RTL and testbench

- Wishbone slave (responder) for the CPU's 16-bit Wishbone master bus.
- Serves each 16-bit bus cycle from an external asynchronous 8-bit SRAM of 1 MB.
- Performs one byte access per selected lane, with programmable wait states, then acknowledges.
- Sits between the bus and the board SRAM pins; the memory decode upstream drives stb/cyc.

---
 rtl/wb_sram8_pkg.sv | 27 ++
 rtl/sram8_byte_cycle.sv | 143 ++++++++++++++
 rtl/wb_sram8_slave.sv | 247 ++++++++++++++++++++++++
 tb/tb_wb_sram8_slave.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_sram8_pkg.sv
// ---------------------------------------------------------------------------
// wb_sram8_pkg
// Shared encodings for the Wishbone-to-8-bit-SRAM bridge:
//   - lane FSM states (top level)
//   - byte-access phases (sram8_byte_cycle)
//   - byte-lane constants used as the SRAM address LSB
// No ports; imported by wb_sram8_slave and sram8_byte_cycle.
// ---------------------------------------------------------------------------
package wb_sram8_pkg;

    // Lane FSM (top level)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LO   = 2'd1;
    localparam logic [1:0] ST_HI   = 2'd2;
    localparam logic [1:0] ST_ACK  = 2'd3;

    // Byte-access phases; PH_IDLE means the pins are parked
    localparam logic [1:0] PH_IDLE   = 2'd0;
    localparam logic [1:0] PH_SETUP  = 2'd1;
    localparam logic [1:0] PH_STROBE = 2'd2;
    localparam logic [1:0] PH_HOLD   = 2'd3;

    // Byte lanes; the lane value is the SRAM byte-address LSB
    localparam logic LANE_LO = 1'b0;
    localparam logic LANE_HI = 1'b1;

endpackage

// File: rtl/sram8_byte_cycle.sv
// ---------------------------------------------------------------------------
// sram8_byte_cycle
// Runs a single byte access on an asynchronous 8-bit SRAM:
//   setup (1 cycle) -> strobe (WAIT cycles) -> hold (1 cycle).
// A start pulse may be issued while idle or during the hold cycle; in the
// latter case the next access follows back to back.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start_i           begin an access (one-cycle pulse)
//   we_i              1 = write, 0 = read (sampled with start_i)
//   addr_i[19:0]      byte address (sampled with start_i)
//   wdata_i[7:0]      write byte (sampled with start_i)
//   done_o            high during the hold cycle (last cycle of the access)
//   rdata_o[7:0]      read byte, captured at the end of the last strobe cycle
//   sram_*            SRAM pins, all registered
//
// Parameter WAIT: strobe length in cycles, legal range 1..15.
// ---------------------------------------------------------------------------
module sram8_byte_cycle
    import wb_sram8_pkg::*;
#(
    parameter int WAIT = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_i,
    input  logic        we_i,
    input  logic [19:0] addr_i,
    input  logic [7:0]  wdata_i,
    output logic        done_o,
    output logic [7:0]  rdata_o,
    output logic [19:0] sram_addr_o,
    input  logic [7:0]  sram_dat_i,
    output logic [7:0]  sram_dat_o,
    output logic        sram_dat_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    localparam logic [3:0] WAIT_C = 4'(WAIT);

    logic [1:0]  phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        is_wr_q, is_wr_d;
    logic [7:0]  rdata_q, rdata_d;
    logic [19:0] addr_q, addr_d;
    logic [7:0]  dat_q, dat_d;
    logic        dat_oe_q, dat_oe_d;
    logic        ce_n_q, ce_n_d;
    logic        oe_n_q, oe_n_d;
    logic        wen_q, wen_d;

    always_comb begin
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        is_wr_d  = is_wr_q;
        rdata_d  = rdata_q;
        addr_d   = addr_q;
        dat_d    = dat_q;
        dat_oe_d = dat_oe_q;
        ce_n_d   = ce_n_q;
        oe_n_d   = oe_n_q;
        wen_d    = wen_q;

        case (phase_q)
            PH_SETUP: begin
                phase_d = PH_STROBE;
                cnt_d   = 4'd1;
                oe_n_d  = is_wr_q;
                wen_d   = !is_wr_q;
            end
            PH_STROBE: begin
                if (cnt_q == WAIT_C) begin
                    // Edge ending the last strobe: release strobes, grab read data
                    phase_d = PH_HOLD;
                    oe_n_d  = 1'b1;
                    wen_d   = 1'b1;
                    if (!is_wr_q) begin
                        rdata_d = sram_dat_i;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            PH_HOLD: begin
                phase_d  = PH_IDLE;
                ce_n_d   = 1'b1;
                dat_oe_d = 1'b0;
            end
            default: ;
        endcase

        // A new access overrides the idle/hold bookkeeping above
        if (start_i) begin
            phase_d  = PH_SETUP;
            is_wr_d  = we_i;
            addr_d   = addr_i;
            dat_d    = wdata_i;
            dat_oe_d = we_i;
            ce_n_d   = 1'b0;
            oe_n_d   = 1'b1;
            wen_d    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q  <= PH_IDLE;
            cnt_q    <= 4'd0;
            is_wr_q  <= 1'b0;
            rdata_q  <= 8'd0;
            addr_q   <= 20'd0;
            dat_q    <= 8'd0;
            dat_oe_q <= 1'b0;
            ce_n_q   <= 1'b1;
            oe_n_q   <= 1'b1;
            wen_q    <= 1'b1;
        end else begin
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            is_wr_q  <= is_wr_d;
            rdata_q  <= rdata_d;
            addr_q   <= addr_d;
            dat_q    <= dat_d;
            dat_oe_q <= dat_oe_d;
            ce_n_q   <= ce_n_d;
            oe_n_q   <= oe_n_d;
            wen_q    <= wen_d;
        end
    end

    assign done_o      = (phase_q == PH_HOLD);
    assign rdata_o     = rdata_q;
    assign sram_addr_o = addr_q;
    assign sram_dat_o  = dat_q;
    assign sram_dat_oe = dat_oe_q;
    assign sram_ce_n   = ce_n_q;
    assign sram_oe_n   = oe_n_q;
    assign sram_we_n   = wen_q;

endmodule

// File: rtl/wb_sram8_slave.sv
// ---------------------------------------------------------------------------
// wb_sram8_slave
// Wishbone slave for a 16-bit master, backed by a 1 MB asynchronous 8-bit
// SRAM. Each selected byte lane becomes one SRAM byte access (low lane
// first); a registered single-cycle ack closes the bus cycle.
//
// Ports:
//   wb_clk_i, wb_rst_i   clock, asynchronous active-low reset
//   wb_adr_i[18:0]       word address (bus bits [19:1])
//   wb_dat_i/wb_dat_o    16-bit write / read data
//   wb_we_i, wb_sel_i    direction, byte lanes (bit0 low byte)
//   wb_stb_i, wb_cyc_i   strobe, cycle valid
//   wb_ack_o             single-cycle acknowledge
//   sram_*               SRAM pins (address, data in/out/oe, ce_n/oe_n/we_n)
//
// Parameter WAIT: strobe cycles per byte access, legal range 1..15.
// Optional build macro SRAM8_RDCACHE_EN: one-entry buffer of the last
// full-word read, served without touching the SRAM.
// ---------------------------------------------------------------------------
module wb_sram8_slave
    import wb_sram8_pkg::*;
#(
    parameter int WAIT = 2
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic [15:0] wb_dat_i,
    output logic [15:0] wb_dat_o,
    input  logic [18:0] wb_adr_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_sel_i,
    input  logic        wb_stb_i,
    input  logic        wb_cyc_i,
    output logic        wb_ack_o,
    output logic [19:0] sram_addr_o,
    input  logic [7:0]  sram_dat_i,
    output logic [7:0]  sram_dat_o,
    output logic        sram_dat_oe,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n
);

    function automatic logic [15:0] lane_mask(input logic [1:0] sel);
        return {{8{sel[1]}}, {8{sel[0]}}};
    endfunction

    logic [1:0]  state_q, state_d;
    logic [18:0] adr_q, adr_d;
    logic        we_q, we_d;
    logic [1:0]  sel_q, sel_d;
    logic [15:0] wdat_q, wdat_d;
    logic        abort_q, abort_d;
    logic [15:0] asm_q, asm_d;      // read word being assembled
    logic [15:0] dat_o_q, dat_o_d;
    logic        ack_q, ack_d;

    logic        accept;
    logic        hit;
    logic [15:0] cache_rd_dat;

    logic        start;
    logic        start_lane;
    logic [18:0] src_adr;
    logic [15:0] src_dat;
    logic        src_we;
    logic        byte_done;
    logic [7:0]  byte_rdata;

    // ack_q in the guard keeps the ack cycle from re-accepting the same request
    assign accept = wb_stb_i && wb_cyc_i && !ack_q && (state_q == ST_IDLE);

    // The first byte access starts on the accept edge, before the request is
    // latched, so it takes its operands straight from the bus.
    assign src_adr = (state_q == ST_IDLE) ? wb_adr_i : adr_q;
    assign src_dat = (state_q == ST_IDLE) ? wb_dat_i : wdat_q;
    assign src_we  = (state_q == ST_IDLE) ? wb_we_i  : we_q;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        we_d       = we_q;
        sel_d      = sel_q;
        wdat_d     = wdat_q;
        abort_d    = abort_q;
        asm_d      = asm_q;
        dat_o_d    = dat_o_q;
        ack_d      = 1'b0;
        start      = 1'b0;
        start_lane = LANE_LO;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    adr_d   = wb_adr_i;
                    we_d    = wb_we_i;
                    sel_d   = wb_sel_i;
                    wdat_d  = wb_dat_i;
                    abort_d = 1'b0;
                    asm_d   = 16'd0;
                    if (hit) begin
                        asm_d   = cache_rd_dat & lane_mask(wb_sel_i);
                        state_d = ST_ACK;
                    end else if (wb_sel_i[0]) begin
                        start      = 1'b1;
                        start_lane = LANE_LO;
                        state_d    = ST_LO;
                    end else if (wb_sel_i[1]) begin
                        start      = 1'b1;
                        start_lane = LANE_HI;
                        state_d    = ST_HI;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_LO: begin
                // A master abort lets the running byte access finish cleanly
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (byte_done) begin
                    if (!we_q) begin
                        asm_d[7:0] = byte_rdata;
                    end
                    if (abort_q || !wb_cyc_i) begin
                        state_d = ST_IDLE;
                    end else if (sel_q[1]) begin
                        start      = 1'b1;
                        start_lane = LANE_HI;
                        state_d    = ST_HI;
                    end else begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_HI: begin
                if (!wb_cyc_i) begin
                    abort_d = 1'b1;
                end
                if (byte_done) begin
                    if (!we_q) begin
                        asm_d[15:8] = byte_rdata;
                    end
                    state_d = (abort_q || !wb_cyc_i) ? ST_IDLE : ST_ACK;
                end
            end
            default: begin
                // ST_ACK: ack and read data become visible together
                ack_d = 1'b1;
                if (!we_q) begin
                    dat_o_d = asm_q;
                end
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state_q <= ST_IDLE;
            adr_q   <= 19'd0;
            we_q    <= 1'b0;
            sel_q   <= 2'b00;
            wdat_q  <= 16'd0;
            abort_q <= 1'b0;
            asm_q   <= 16'd0;
            dat_o_q <= 16'd0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            we_q    <= we_d;
            sel_q   <= sel_d;
            wdat_q  <= wdat_d;
            abort_q <= abort_d;
            asm_q   <= asm_d;
            dat_o_q <= dat_o_d;
            ack_q   <= ack_d;
        end
    end

`ifdef SRAM8_RDCACHE_EN
    logic        cache_vld_q, cache_vld_d;
    logic [18:0] cache_adr_q, cache_adr_d;
    logic [15:0] cache_dat_q, cache_dat_d;

    assign hit          = cache_vld_q && !wb_we_i && (wb_adr_i == cache_adr_q);
    assign cache_rd_dat = cache_dat_q;

    always_comb begin
        cache_vld_d = cache_vld_q;
        cache_adr_d = cache_adr_q;
        cache_dat_d = cache_dat_q;
        // Writes patch the entry at accept time so a read right behind them
        // can never return stale bytes.
        if (accept && wb_we_i && cache_vld_q && (wb_adr_i == cache_adr_q)) begin
            if (wb_sel_i[0]) cache_dat_d[7:0]  = wb_dat_i[7:0];
            if (wb_sel_i[1]) cache_dat_d[15:8] = wb_dat_i[15:8];
        end
        if ((state_q == ST_ACK) && !we_q && (sel_q == 2'b11)) begin
            cache_vld_d = 1'b1;
            cache_adr_d = adr_q;
            cache_dat_d = asm_q;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            cache_vld_q <= 1'b0;
            cache_adr_q <= 19'd0;
            cache_dat_q <= 16'd0;
        end else begin
            cache_vld_q <= cache_vld_d;
            cache_adr_q <= cache_adr_d;
            cache_dat_q <= cache_dat_d;
        end
    end
`else
    assign hit          = 1'b0;
    assign cache_rd_dat = 16'd0;
`endif

    sram8_byte_cycle #(
        .WAIT (WAIT)
    ) u_byte (
        .clk         (wb_clk_i),
        .rst_n       (wb_rst_i),
        .start_i     (start),
        .we_i        (src_we),
        .addr_i      ({src_adr, start_lane}),
        .wdata_i     ((start_lane == LANE_HI) ? src_dat[15:8] : src_dat[7:0]),
        .done_o      (byte_done),
        .rdata_o     (byte_rdata),
        .sram_addr_o (sram_addr_o),
        .sram_dat_i  (sram_dat_i),
        .sram_dat_o  (sram_dat_o),
        .sram_dat_oe (sram_dat_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    assign wb_dat_o = dat_o_q;
    assign wb_ack_o = ack_q;

endmodule

// File: tb/tb_wb_sram8_slave.sv
// ---------------------------------------------------------------------------
// tb_wb_sram8_slave
// Directed bench for wb_sram8_slave (WAIT=2) with a behavioural 1 MB SRAM.
// Define SRAM8_RDCACHE_EN to also exercise the read buffer.
// ---------------------------------------------------------------------------
module tb_wb_sram8_slave;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] wb_dat_i;
    logic [15:0] wb_dat_o;
    logic [18:0] wb_adr_i;
    logic        wb_we_i;
    logic [1:0]  wb_sel_i;
    logic        wb_stb_i;
    logic        wb_cyc_i;
    logic        wb_ack_o;
    logic [19:0] sram_addr_o;
    logic [7:0]  sram_dat_i;
    logic [7:0]  sram_dat_o;
    logic        sram_dat_oe;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    wb_sram8_slave #(.WAIT(2)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst_n),
        .wb_dat_i    (wb_dat_i),
        .wb_dat_o    (wb_dat_o),
        .wb_adr_i    (wb_adr_i),
        .wb_we_i     (wb_we_i),
        .wb_sel_i    (wb_sel_i),
        .wb_stb_i    (wb_stb_i),
        .wb_cyc_i    (wb_cyc_i),
        .wb_ack_o    (wb_ack_o),
        .sram_addr_o (sram_addr_o),
        .sram_dat_i  (sram_dat_i),
        .sram_dat_o  (sram_dat_o),
        .sram_dat_oe (sram_dat_oe),
        .sram_ce_n   (sram_ce_n),
        .sram_oe_n   (sram_oe_n),
        .sram_we_n   (sram_we_n)
    );

    // Behavioural SRAM: reads drive the bus only while ce_n and oe_n are low
    logic [7:0] mem [0:1048575];
    assign sram_dat_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr_o] : 8'hEE;

    // Pin monitor, counts cycles per transaction
    int ce_cnt, idle_cnt, oe_cnt, we_cnt, ack_cnt;
    logic [27:0] wr_log [$];
    logic [19:0] rd_log [$];
    logic prev_we = 1'b1;
    logic prev_oe = 1'b1;

    always @(posedge clk) begin
        if (!sram_ce_n) ce_cnt++;
        if (!sram_ce_n && sram_oe_n && sram_we_n) idle_cnt++;
        if (!sram_oe_n) oe_cnt++;
        if (!sram_we_n) begin
            we_cnt++;
            if (prev_we) wr_log.push_back({sram_addr_o, sram_dat_o});
            mem[sram_addr_o] = sram_dat_o;
        end
        if (!sram_oe_n && prev_oe) rd_log.push_back(sram_addr_o);
        if (wb_ack_o) ack_cnt++;
        prev_we = sram_we_n;
        prev_oe = sram_oe_n;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] wr_at(input int i);
        return (i < wr_log.size()) ? {4'h0, wr_log[i]} : 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] rd_at(input int i);
        return (i < rd_log.size()) ? {12'h0, rd_log[i]} : 32'hDEAD_BEEF;
    endfunction

    task automatic clear_mon();
        ce_cnt = 0; idle_cnt = 0; oe_cnt = 0; we_cnt = 0; ack_cnt = 0;
        wr_log.delete();
        rd_log.delete();
    endtask

    // One bus cycle; lat = edges from accept to ack high (0 if it never came)
    task automatic do_req(input logic [18:0] adr, input logic we, input logic [1:0] sel,
                          input logic [15:0] dat, output int lat);
        @(posedge clk); #1;
        clear_mon();
        wb_adr_i = adr; wb_we_i = we; wb_sel_i = sel; wb_dat_i = dat;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        lat = 0;
        @(posedge clk);  // accept edge
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (wb_ack_o) begin
                lat = i;
                break;
            end
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
    endtask

    int lat;
    logic [3:0] pat;

    initial begin
        for (int i = 0; i < 1048576; i++) mem[i] = 8'h00;
        mem[20'hFFFFE] = 8'h3C;
        mem[20'hFFFFF] = 8'hC3;
        rst_n = 1'b0;
        wb_dat_i = 16'd0; wb_adr_i = 19'd0; wb_we_i = 1'b0; wb_sel_i = 2'b00;
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        clear_mon();

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_ack",   {31'd0, wb_ack_o}, 32'd0);
        check_eq("rst_dat_o", {16'd0, wb_dat_o}, 32'd0);
        check_eq("rst_addr",  {12'd0, sram_addr_o}, 32'd0);
        check_eq("rst_sdat",  {24'd0, sram_dat_o}, 32'd0);
        check_eq("rst_pins",  {28'd0, sram_dat_oe, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Word write A55A at word 0x10
        do_req(19'h00010, 1'b1, 2'b11, 16'hA55A, lat);
        check_eq("wr_word_lat",  lat, 32'd9);
        check_eq("wr_word_we",   we_cnt, 32'd4);
        check_eq("wr_word_oe",   oe_cnt, 32'd0);
        check_eq("wr_word_ce",   ce_cnt, 32'd8);
        check_eq("wr_word_sh",   idle_cnt, 32'd4);
        check_eq("wr_word_n",    wr_log.size(), 32'd2);
        check_eq("wr_word_b0",   wr_at(0), {4'h0, 20'h00020, 8'h5A});
        check_eq("wr_word_b1",   wr_at(1), {4'h0, 20'h00021, 8'hA5});

        // High-lane read of the same word
        do_req(19'h00010, 1'b0, 2'b10, 16'h0000, lat);
        check_eq("rd_hi_lat",  lat, 32'd5);
        check_eq("rd_hi_dat",  {16'd0, wb_dat_o}, 32'h0000A500);
        check_eq("rd_hi_ce",   ce_cnt, 32'd4);
        check_eq("rd_hi_oe",   oe_cnt, 32'd2);
        check_eq("rd_hi_addr", rd_at(0), 32'h00021);

        // Full-word read back
        do_req(19'h00010, 1'b0, 2'b11, 16'h0000, lat);
        check_eq("rd_word_lat", lat, 32'd9);
        check_eq("rd_word_dat", {16'd0, wb_dat_o}, 32'h0000A55A);
        check_eq("rd_word_oe",  oe_cnt, 32'd4);
        check_eq("rd_word_we",  we_cnt, 32'd0);

`ifdef SRAM8_RDCACHE_EN
        do_req(19'h00010, 1'b0, 2'b11, 16'h0000, lat);
        check_eq("rc_hit_lat", lat, 32'd1);
        check_eq("rc_hit_ce",  ce_cnt, 32'd0);
        check_eq("rc_hit_dat", {16'd0, wb_dat_o}, 32'h0000A55A);
        do_req(19'h00010, 1'b1, 2'b11, 16'h1234, lat);
        check_eq("rc_wr_lat",  lat, 32'd9);
        do_req(19'h00010, 1'b0, 2'b11, 16'h0000, lat);
        check_eq("rc_upd_lat", lat, 32'd1);
        check_eq("rc_upd_dat", {16'd0, wb_dat_o}, 32'h00001234);
        check_eq("rc_upd_ce",  ce_cnt, 32'd0);
        do_req(19'h00010, 1'b0, 2'b01, 16'h0000, lat);
        check_eq("rc_lo_lat",  lat, 32'd1);
        check_eq("rc_lo_dat",  {16'd0, wb_dat_o}, 32'h00000034);
`endif

        // Low-lane read at the top of memory
        do_req(19'h7FFFF, 1'b0, 2'b01, 16'h0000, lat);
        check_eq("rd_top_lat",  lat, 32'd5);
        check_eq("rd_top_dat",  {16'd0, wb_dat_o}, 32'h0000003C);
        check_eq("rd_top_addr", rd_at(0), 32'hFFFFE);

        // Low-lane write, then word read: unwritten high byte reads 00
        do_req(19'h00030, 1'b1, 2'b01, 16'h99C7, lat);
        check_eq("wr_lo_lat", lat, 32'd5);
        check_eq("wr_lo_n",   wr_log.size(), 32'd1);
        check_eq("wr_lo_b0",  wr_at(0), {4'h0, 20'h00060, 8'hC7});
        do_req(19'h00030, 1'b0, 2'b11, 16'h0000, lat);
        check_eq("rd_30_lat", lat, 32'd9);
        check_eq("rd_30_dat", {16'd0, wb_dat_o}, 32'h000000C7);

        // No lanes selected
        do_req(19'h00055, 1'b0, 2'b00, 16'h0000, lat);
        check_eq("sel0_lat", lat, 32'd1);
        check_eq("sel0_ce",  ce_cnt, 32'd0);
        check_eq("sel0_dat", {16'd0, wb_dat_o}, 32'd0);

        // Back-to-back with stb held: ack, blocked edge, accept, ack
        @(posedge clk); #1;
        wb_adr_i = 19'h00055; wb_we_i = 1'b1; wb_sel_i = 2'b00;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        @(posedge clk);
        for (int i = 3; i >= 0; i--) begin
            @(posedge clk); #1;
            pat[i] = wb_ack_o;
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        check_eq("b2b_ack_pat", {28'd0, pat}, 32'b1001);
        repeat (2) @(posedge clk);

        // Master abort during the low-lane strobe of a word write
        @(posedge clk); #1;
        clear_mon();
        wb_adr_i = 19'h00020; wb_we_i = 1'b1; wb_sel_i = 2'b11; wb_dat_i = 16'hBEEF;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!sram_we_n) break;
        end
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        check_eq("abort_ack", ack_cnt, 32'd0);
        check_eq("abort_n",   wr_log.size(), 32'd1);
        check_eq("abort_b0",  wr_at(0), {4'h0, 20'h00040, 8'hEF});
        check_eq("abort_we",  we_cnt, 32'd2);
        check_eq("abort_ce",  ce_cnt, 32'd4);
        check_eq("abort_sh",  idle_cnt, 32'd2);
        do_req(19'h00020, 1'b0, 2'b01, 16'h0000, lat);
        check_eq("post_abort_lat", lat, 32'd5);
        check_eq("post_abort_dat", {16'd0, wb_dat_o}, 32'h000000EF);

        // Reset asserted mid-strobe of a write
        @(posedge clk); #1;
        wb_adr_i = 19'h00070; wb_we_i = 1'b1; wb_sel_i = 2'b11; wb_dat_i = 16'h1111;
        wb_stb_i = 1'b1; wb_cyc_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (!sram_we_n) break;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_pins", {28'd0, sram_dat_oe, sram_ce_n, sram_oe_n, sram_we_n}, 32'h7);
        check_eq("mid_rst_ack",  {31'd0, wb_ack_o}, 32'd0);
        check_eq("mid_rst_addr", {12'd0, sram_addr_o}, 32'd0);
        wb_stb_i = 1'b0; wb_cyc_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Normal operation after reset (also a buffer miss when enabled)
        do_req(19'h00030, 1'b0, 2'b11, 16'h0000, lat);
        check_eq("post_rst_lat", lat, 32'd9);
        check_eq("post_rst_dat", {16'd0, wb_dat_o}, 32'h000000C7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
